// File: rtl/wb_mem_slave_pkg.sv
// rtl/wb_mem_slave_pkg.sv - shared core widths and response-stage types for wb_mem_slave
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

package wb_mem_slave_pkg;

  localparam int unsigned CORE_AW  = `CORE_ADDR_WIDTH;
  localparam int unsigned CORE_DW  = `CORE_DATA_WIDTH;
  localparam int unsigned CORE_BEW = `CORE_BE_WIDTH;

  localparam int unsigned WB_MEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic               val;
    logic               err;
    logic               we;
    logic [CORE_DW-1:0] data;
  } wb_mem_stage_t;

endpackage

// File: rtl/wb_mem_array.sv
// rtl/wb_mem_array.sv - single-port byte-enable synchronous RAM, 1-cycle read, write-first
module wb_mem_array
  import wb_mem_slave_pkg::*;
#(
  parameter int unsigned AWIDTH = 10
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [CORE_BEW-1:0] be_i,
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [CORE_DW-1:0]  wdata_i,
  output logic [CORE_DW-1:0]  rdata_o
);

  logic [CORE_DW-1:0] mem_q [2**AWIDTH];
  logic [CORE_DW-1:0] rdata_q;
  logic [CORE_DW-1:0] merged_d;

  always_comb begin
    merged_d = mem_q[addr_i];
    for (int b = 0; b < int'(CORE_BEW); b++) begin
      if (be_i[b]) merged_d[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  // Write-first: a write also presents the merged word on the read port.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= merged_d;
        rdata_q       <= merged_d;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - Wishbone B4 pipelined memory slave with fixed latency, stall injection and range error
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int unsigned         MEM_AWIDTH   = 10,
  parameter logic [CORE_AW-1:0]  BASE_ADDR    = '0,
  parameter int unsigned         LATENCY      = 2,
  parameter int unsigned         STALL_PERIOD = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [CORE_AW-1:0]  wb_adr_i,
  input  logic [CORE_BEW-1:0] wb_sel_i,
  input  logic [CORE_DW-1:0]  wb_dat_i,
  output logic [CORE_DW-1:0]  wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CORE_AW:0] WIN_BYTES = (CORE_AW+1)'(1) << (MEM_AWIDTH + 2);

  logic [CORE_AW-1:0]    off;
  logic                  in_range;
  logic                  acc;
  logic                  stall;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CORE_DW-1:0]    ram_rdata;
  logic                  s0_val_q, s0_err_q, s0_we_q;
  logic                  s0_val_d, s0_err_d, s0_we_d;
  wb_mem_stage_t         pipe_q [1:LATENCY];
  wb_mem_stage_t         pipe_d [1:LATENCY];

  assign off      = wb_adr_i - BASE_ADDR;
  assign in_range = ({1'b0, off} < WIN_BYTES);

  always_comb begin
    cnt_d = '0;
    stall = 1'b0;
    if (STALL_PERIOD != 0 && wb_cyc_i) begin
      stall = (cnt_q == CNT_W'(STALL_PERIOD - 1));
      cnt_d = stall ? '0 : cnt_q + 8'd1;
    end
  end

  assign acc = wb_cyc_i & wb_stb_i & ~stall;

  wb_mem_array #(
    .AWIDTH (MEM_AWIDTH)
  ) u_array (
    .clk_i   (wb_clk_i),
    .en_i    (acc & in_range),
    .we_i    (wb_we_i),
    .be_i    (wb_sel_i),
    .addr_i  (off[MEM_AWIDTH+1:2]),
    .wdata_i (wb_dat_i),
    .rdata_o (ram_rdata)
  );

  // Stage 0 control rides alongside the RAM output register, which holds its data.
  always_comb begin
    s0_val_d = acc;
    s0_err_d = ~in_range;
    s0_we_d  = wb_we_i;
    pipe_d[1].val  = s0_val_q;
    pipe_d[1].err  = s0_err_q;
    pipe_d[1].we   = s0_we_q;
    pipe_d[1].data = (s0_val_q & ~s0_err_q & ~s0_we_q) ? ram_rdata : '0;
    for (int i = 2; i <= int'(LATENCY); i++) pipe_d[i] = pipe_q[i-1];
    if (!wb_cyc_i) begin
      for (int i = 1; i <= int'(LATENCY); i++) pipe_d[i] = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cnt_q    <= '0;
      s0_val_q <= 1'b0;
      s0_err_q <= 1'b0;
      s0_we_q  <= 1'b0;
      for (int i = 1; i <= int'(LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      s0_val_q <= s0_val_d;
      s0_err_q <= s0_err_d;
      s0_we_q  <= s0_we_d;
      for (int i = 1; i <= int'(LATENCY); i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign wb_ack_o   = pipe_q[LATENCY].val & ~pipe_q[LATENCY].err;
  assign wb_err_o   = pipe_q[LATENCY].val &  pipe_q[LATENCY].err;
  assign wb_dat_o   = pipe_q[LATENCY].data;
  assign wb_stall_o = stall;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - self-checking bench for wb_mem_slave
module tb_wb_mem_slave;
  import wb_mem_slave_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          edge_n;
  } exp_t;

  logic clk;
  logic rst_n;
  logic cyc0, cyc1, stb, we;
  logic [CORE_AW-1:0]  adr;
  logic [CORE_BEW-1:0] sel;
  logic [CORE_DW-1:0]  dat;
  logic [CORE_DW-1:0]  dat0, dat1;
  logic ack0, ack1, err0, err1, stall0, stall1;
  logic sel_dut;

  logic cur_ack, cur_err, cur_stall, cur_cyc;
  logic [31:0] cur_dat;

  int tests_run;
  int tests_failed;
  int cyc_cnt;
  int resp_cnt;
  int stall_seen;
  exp_t exp_q[$];
  vec_t vecs[$];

  wb_mem_slave #(
    .MEM_AWIDTH(10), .BASE_ADDR(32'h0), .LATENCY(2), .STALL_PERIOD(0)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat0),
    .wb_ack_o(ack0), .wb_err_o(err0), .wb_stall_o(stall0)
  );

  wb_mem_slave #(
    .MEM_AWIDTH(10), .BASE_ADDR(32'h0), .LATENCY(2), .STALL_PERIOD(3)
  ) u_dut_st (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat1),
    .wb_ack_o(ack1), .wb_err_o(err1), .wb_stall_o(stall1)
  );

  assign cur_ack   = sel_dut ? ack1   : ack0;
  assign cur_err   = sel_dut ? err1   : err0;
  assign cur_stall = sel_dut ? stall1 : stall0;
  assign cur_cyc   = sel_dut ? cyc1   : cyc0;
  assign cur_dat   = sel_dut ? dat1   : dat0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cur_cyc && stb && cur_stall) stall_seen++;
      if (cur_ack && cur_err) chk("ack_and_err", 32'd1, 32'd0);
      if (cur_ack || cur_err) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_err", {31'd0, cur_err}, {31'd0, e.err});
          chk("resp_ack", {31'd0, cur_ack}, {31'd0, ~e.err});
          chk("resp_dat", cur_dat, e.dat);
          chk("resp_latency", 32'(cyc_cnt - e.edge_n), 32'd2);
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic ee, input logic [31:0] ed);
    bit done;
    done = 0;
    stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      if (!cur_stall) begin
        exp_q.push_back('{err: ee, dat: ed, edge_n: cyc_cnt + 1});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_ack"}, {31'd0, cur_ack}, 32'd0);
    chk({name, "_err"}, {31'd0, cur_err}, 32'd0);
    chk({name, "_dat"}, cur_dat, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    tests_run = 0; tests_failed = 0; cyc_cnt = 0; resp_cnt = 0; stall_seen = 0;
    sel_dut = 1'b0;
    cyc0 = 0; cyc1 = 0; stb = 0; we = 0; adr = '0; sel = '0; dat = '0;

    vecs.push_back('{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,       4'hF, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h20,       4'hF, 32'h11223344, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,       4'hF, 32'h0,        1'b0, 32'h11BB33DD});
    vecs.push_back('{1'b1, 32'h10,       4'h0, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h13,       4'hF, 32'h0,        1'b0, 32'hDEADBEEF});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 32'h40 + 32'(4*i), 4'hF, 32'(i+1), 1'b0, 32'h0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 32'h40 + 32'(4*i), 4'hF, 32'h0, 1'b0, 32'(i+1)});
    vecs.push_back('{1'b0, 32'h40,       4'h0, 32'h0,        1'b0, 32'h1});
    vecs.push_back('{1'b1, 32'h0,        4'hF, 32'h5A5A5A5A, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h1000,     4'hF, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h1000,     4'hF, 32'hFFFFFFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'hF, 32'h0,        1'b0, 32'h5A5A5A5A});
    vecs.push_back('{1'b1, 32'hFFC,      4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'hFFC,      4'hF, 32'h0,        1'b0, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        1'b1, 32'h0});

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_quiet("reset");
    chk("reset_stall0", {31'd0, stall0}, 32'd0);
    chk("reset_stall1", {31'd0, stall1}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Table vectors, issued back-to-back within one bus cycle.
    cyc0 = 1'b1;
    foreach (vecs[i]) do_req(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                             vecs[i].exp_err, vecs[i].exp_dat);
    stb = 1'b0;
    repeat (4) step();
    chk("table_drained", 32'(exp_q.size()), 32'd0);
    cyc0 = 1'b0;
    step();

    // Stall pattern with STALL_PERIOD=3, then an 8-request burst.
    sel_dut = 1'b1;
    cyc1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_pattern", {31'd0, stall1}, {31'd0, (k % 3) == 2});
      step();
    end
    cyc1 = 1'b0;
    @(negedge clk);
    chk("stall_no_cyc", {31'd0, stall1}, 32'd0);
    step();
    cyc1 = 1'b1;
    stall_seen = 0;
    r0 = resp_cnt;
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'h80 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'h80 + 32'(4*i), 4'hF, 32'h0, 1'b0, 32'hA0 + 32'(i));
    stb = 1'b0;
    repeat (4) step();
    chk("stall_burst_resp", 32'(resp_cnt - r0), 32'd8);
    chk("stall_burst_stalls", 32'(stall_seen), 32'd3);
    cyc1 = 1'b0;
    step();
    sel_dut = 1'b0;

    // Abort: drop cyc right after the second accept.
    cyc0 = 1'b1;
    do_req(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h1);
    do_req(1'b0, 32'h44, 4'hF, 32'h0, 1'b0, 32'h2);
    cyc0 = 1'b0;
    stb = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_quiet("abort");
      step();
    end
    cyc0 = 1'b1;
    do_req(1'b0, 32'h4C, 4'hF, 32'h0, 1'b0, 32'h4);
    stb = 1'b0;
    repeat (4) step();
    cyc0 = 1'b0;
    step();

    // Reset asserted while responses are in flight.
    cyc0 = 1'b1;
    do_req(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h1);
    do_req(1'b0, 32'h44, 4'hF, 32'h0, 1'b0, 32'h2);
    do_req(1'b0, 32'h48, 4'hF, 32'h0, 1'b0, 32'h3);
    chk("pre_reset_ack", {31'd0, ack0}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    exp_q.delete();
    stb = 1'b0;
    cyc0 = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check_quiet("post_reset");
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Wishbone B4 pipelined slave with on-chip word memory, byte-enable writes and fixed response latency.
- Sits directly downstream of the L1 memory access unit and consumes its cyc/stb/we/sel/adr/dat stream.
- Serves 4-beat line refills, single-beat nc reads and single-beat stores.
- Provides programmable stall injection and address-range error so the master's stall/ack/err paths can be exercised.

Parameters:
- MEM_AWIDTH, 10, word-address bits; memory holds 2**MEM_AWIDTH words of `CORE_DATA_WIDTH.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**MEM_AWIDTH.
- LATENCY, 2, cycles from accept to ack/err; legal range 1..4.
- STALL_PERIOD, 0, inject one stall cycle every STALL_PERIOD cycles; 0 disables; 1 is illegal.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  `CORE_ADDR_WIDTH  byte address, bits [1:0] ignored
- wb_sel_i  in  `CORE_BE_WIDTH  byte enables
- wb_dat_i  in  `CORE_DATA_WIDTH  write data
- wb_dat_o  out  `CORE_DATA_WIDTH  read data, valid with wb_ack_o
- wb_ack_o  out  1  successful completion
- wb_err_o  out  1  error completion (out of range)
- wb_stall_o  out  1  request not accepted this cycle

Behaviour:
- Reset:
  - Clock and reset are one clock and an asynchronous, active-low reset.
  - Reset clears wb_ack_o, wb_err_o and wb_stall_o to 0, wb_dat_o to 0, all pipeline valids to 0 and the stall counter to 0.
  - Memory contents are not reset.
- Accept:
  - acc = wb_cyc_i & wb_stb_i & ~wb_stall_o.
  - One request is accepted per cycle at most.
  - Back-to-back accepts are allowed every cycle.
- Range check:
  - in_range = (wb_adr_i - BASE_ADDR) < 4*2**MEM_AWIDTH, unsigned.
  - idx = (wb_adr_i - BASE_ADDR)[MEM_AWIDTH+1:2].
- Write:
  - On acc & wb_we_i & in_range, update byte lane b of mem[idx] with wb_dat_i lane b for every b where wb_sel_i[b]=1, in the accept cycle.
  - sel=0 writes nothing but still acks.
- Read:
  - On acc & ~wb_we_i & in_range, mem[idx] is registered into pipeline stage 0.
  - Read data ignores sel; full word is returned.
  - A read accepted the cycle after a write to the same word returns the new data.
- Response pipeline:
  - LATENCY stages; each stage holds {val, err, we, data}, shifting every cycle.
  - An accepted request appears on the bus exactly LATENCY cycles after its accept edge:
    - wb_ack_o=1 if in range, else wb_err_o=1.
  - Ack and err are never both 1.
  - wb_dat_o = read data on read ack; 0 on write ack or err.
  - Responses stay in request order; no response backpressure exists.
- Out of range: no memory access; err is returned with the same latency as an ack.
- Stall:
  - Counter runs 0..STALL_PERIOD-1 whenever wb_cyc_i=1 and holds at 0 when wb_cyc_i=0.
  - wb_stall_o = (cnt == STALL_PERIOD-1) & wb_cyc_i, and is combinational from cnt and cyc.
  - With STALL_PERIOD=0, wb_stall_o is constantly 0.
- Cycle abort: wb_cyc_i=0 clears all pipeline valids in the same cycle, so no ack or err appears after cyc drops. Writes already committed are kept.
- stb without cyc is ignored.
- Reset mid-burst drops all pending responses.

Decomposition:
- `CORE_ADDR_WIDTH, `CORE_DATA_WIDTH and `CORE_BE_WIDTH come from the shared core defines.
- Add to the shared package:
  - WB_MEM_MAX_LATENCY=4;
  - a response-stage struct/typedef {val, err, we, data}.
- One sub-module: wb_mem_array, a single-port byte-enable synchronous RAM (1-cycle read, write-first).
- The top block holds the range check, stall counter and latency pipeline.

Test Plan:
- LATENCY=2, STALL_PERIOD=0: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 the next cycle -> ack on cycles 2 and 3 after the write accept; read dat=0xDEADBEEF.
- Byte enables: word 0x20 = 0x11223344; write 0xAABBCCDD with sel=4'b0101; read -> 0x11BB33DD.
- Burst: 4 back-to-back reads 0x40..0x4C preloaded 1,2,3,4 -> 4 consecutive acks starting at accept+LATENCY, data 1,2,3,4, in order.
- STALL_PERIOD=3, 4-beat burst -> stall on every third cycle; the same address is held and later accepted; exactly 4 acks; data correct.
- MEM_AWIDTH=10, BASE_ADDR=0: read 0x1000 -> wb_err_o=1 after LATENCY cycles, ack=0, dat=0. Write 0x1000 -> err and no memory change (verified by reading 0x000).
- Abort: issue 2 reads, drop cyc one cycle after the second accept -> no ack or err afterwards. Reset asserted mid-burst -> all outputs 0 immediately.
